scs8hd_rr_arb4: RTL and testbench
=================================

Name: scs8hd_rr_arb4

Overview:
- Four-requester round-robin arbiter that shares one resource slot, such as a shared 4-input AND/gating path or a shared cell-test port, between four clients.
- Grants are registered, exclusive and held while the winner keeps requesting.
- Sits between client request lines and the resource's select/enable inputs. The one-hot grant drives the resource mux directly.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release. Used only with the optional feature. Legal range 2..255.
- RESET_PTR, 0, index (0..3) that has highest priority after reset.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- REQ  input  4  per-client request, level; bit i = client i
- GNT  output  4  one-hot-or-zero grant, registered
- GNT_VALID  output  1  OR of GNT, registered
- GNT_ID  output  2  index of granted client; 0 when GNT_VALID=0
- TIMEOUT  output  1  one-cycle pulse on forced release (0 when feature compiled out)

Behaviour:
- Single clock CLK. RESET is synchronous and active-high, sampled on the CLK rising edge. The clock and reset port names are CLK and RESET.
- Reset values: GNT=0, GNT_VALID=0, GNT_ID=0, TIMEOUT=0, state=IDLE, ptr=RESET_PTR, hold count=0, mask=0.
- States: IDLE (no grant) and BUSY (one grant held).
- IDLE to BUSY: if any unmasked REQ is set at edge N, GNT is set at edge N (visible in cycle N+1).
  - Request-to-grant latency is 1 cycle.
  - Winner is the first set bit scanning ptr, ptr+1, ... modulo 4.
- BUSY hold: stays in BUSY while REQ[GNT_ID]=1. GNT is stable. Other requests are ignored.
- BUSY release: on the cycle REQ[GNT_ID]=0:
  - ptr <= GNT_ID+1 (mod 4, wraps 3 to 0).
  - Arbitration runs the same cycle over the remaining REQ, with the new pointer applied.
  - If another request exists, GNT switches directly to the new winner at the next edge (zero idle cycles, never two bits set).
  - Otherwise the arbiter goes to IDLE with GNT=0.
- Simultaneous events:
  - Release and new request in the same cycle resolve as above.
  - A client that drops and re-raises REQ in consecutive cycles gets the lowest priority among pending clients.
- REQ dropping in IDLE needs no action. Grants are never issued to a client with REQ=0.
- RESET asserted mid-grant: GNT clears at that edge. All state returns to reset values regardless of REQ.
- Invariants:
  - popcount(GNT) <= 1 every cycle.
  - GNT_VALID == |GNT.
  - GNT_ID encodes GNT.

Optional Feature:
- Macro: SCS8HD_ARB_TIMEOUT_EN.
- Defined:
  - Hold counter of width $clog2(MAX_HOLD+1) counts grant cycles.
  - When a client has held GNT for MAX_HOLD cycles with REQ still high, the grant is forced to release at that edge and TIMEOUT pulses for 1 cycle.
  - ptr advances as on a normal release, and the new winner is granted at the same edge.
  - The forced client's mask bit is set. A masked client is excluded from arbitration until its REQ drops, which clears the mask.
  - The counter resets on every grant change.
- Undefined: no counter and no mask logic. TIMEOUT is tied to 0. Grants are held indefinitely.

Decomposition:
- Package scs8hd_arb_pkg contains:
  - state enum (ARB_IDLE, ARB_BUSY)
  - ARB_N=4
  - ARB_IDW=2
  - onehot-to-index function
- Sub-module scs8hd_rr_pick4: purely combinational rotating priority encoder. Inputs are the 4-bit request and the 2-bit pointer. Outputs are the one-hot pick and a valid flag. It is instantiated once.

Test Plan:
- Reset priority: RESET for 2 cycles, RESET_PTR=0, REQ=4'b1010 -> cycle after: GNT=4'b0010, GNT_ID=1. Hold REQ for 5 cycles -> GNT unchanged.
- Round-robin rotation: REQ=4'b1111 continuously; each client drops its REQ for 1 cycle after 3 grant cycles -> grant order 0,1,2,3,0, with no idle cycle between grants and popcount(GNT)<=1 throughout.
- Wrap-around: ptr=3 (after granting client 2), REQ=4'b0001 and client 2 releases -> next GNT=4'b0001. Then client 0 releases and REQ=4'b1000 -> GNT=4'b1000.
- Release to empty: only client 2 requesting, it drops REQ -> next cycle GNT=0, GNT_VALID=0, GNT_ID=0. Then REQ=4'b0100 -> granted 1 cycle later.
- Reset mid-grant: GNT=4'b0100, assert RESET with REQ=4'b1111 -> GNT=0 at that edge. Deassert -> GNT=4'b0001 (RESET_PTR=0) one cycle later.
- Timeout (SCS8HD_ARB_TIMEOUT_EN, MAX_HOLD=4): client 1 holds REQ, client 3 requests -> after 4 grant cycles TIMEOUT=1 for 1 cycle and GNT=4'b1000. Client 1 is not regranted until its REQ drops and rises again. With the macro undefined -> client 1 is held indefinitely and TIMEOUT stays 0.

Source files
------------

// File: rtl/scs8hd_arb_pkg.sv
// Shared types, sizes and helpers for the scs8hd 4-way round-robin arbiter.
package scs8hd_arb_pkg;

    localparam int unsigned ARB_N   = 4;
    localparam int unsigned ARB_IDW = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic logic [ARB_IDW-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
        logic [ARB_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (oh[i]) idx = idx | ARB_IDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scs8hd_rr_pick4.sv
// Combinational rotating priority encoder: first set request scanning ptr, ptr+1, ... mod 4.
module scs8hd_rr_pick4
    import scs8hd_arb_pkg::*;
(
    input  logic [ARB_N-1:0]   req,
    input  logic [ARB_IDW-1:0] ptr,
    output logic [ARB_N-1:0]   pick_c,
    output logic               valid_c
);

    logic [ARB_IDW-1:0] idx;
    logic               found;

    always_comb begin
        pick_c = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < ARB_N; k++) begin
            idx = ptr + ARB_IDW'(k);
            if (!found && req[idx]) begin
                pick_c[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_c = found;

endmodule

// File: rtl/scs8hd_rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional forced release after MAX_HOLD cycles: define SCS8HD_ARB_TIMEOUT_EN.
module scs8hd_rr_arb4
    import scs8hd_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned RESET_PTR = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ARB_N-1:0]   REQ,
    output logic [ARB_N-1:0]   GNT,
    output logic               GNT_VALID,
    output logic [ARB_IDW-1:0] GNT_ID,
    output logic               TIMEOUT
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || RESET_PTR > 3) begin : g_param_check
        $error("scs8hd_rr_arb4: MAX_HOLD or RESET_PTR out of range");
    end

    arb_state_e         state, state_nxt;
    logic [ARB_IDW-1:0] ptr, ptr_nxt, pick_ptr_c, gnt_id_nxt;
    logic [ARB_N-1:0]   gnt_nxt, elig_c, pick_c;
    logic               pick_valid_c, gnt_valid_nxt, timeout_nxt;
    logic               cur_req_c, force_c, release_c;

    assign cur_req_c  = REQ[GNT_ID];
    assign release_c  = (state == ARB_BUSY) && (!cur_req_c || force_c);
    assign pick_ptr_c = release_c ? GNT_ID + ARB_IDW'(1) : ptr;

`ifdef SCS8HD_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [ARB_N-1:0] mask, mask_nxt;

    // hold_cnt is 0 in the first grant cycle, so MAX_HOLD-1 marks the last allowed one.
    assign force_c = (state == ARB_BUSY) && cur_req_c && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign elig_c  = REQ & ~mask & ~(force_c ? GNT : '0);

    always_comb begin
        hold_cnt_nxt = '0;
        mask_nxt     = (mask | (force_c ? GNT : '0)) & REQ;
        if (state == ARB_BUSY && !release_c) hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_cnt <= '0;
            mask     <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            mask     <= mask_nxt;
        end
    end
`else
    assign force_c = 1'b0;
    assign elig_c  = REQ;
`endif

    scs8hd_rr_pick4 u_pick (
        .req     (elig_c),
        .ptr     (pick_ptr_c),
        .pick_c  (pick_c),
        .valid_c (pick_valid_c)
    );

    // Next-state and next-output logic; a release re-arbitrates in the same cycle.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = GNT;
        gnt_id_nxt    = GNT_ID;
        gnt_valid_nxt = GNT_VALID;
        timeout_nxt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid_c) begin
                    state_nxt     = ARB_BUSY;
                    gnt_nxt       = pick_c;
                    gnt_id_nxt    = onehot_to_idx(pick_c);
                    gnt_valid_nxt = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (release_c) begin
                    ptr_nxt     = pick_ptr_c;
                    timeout_nxt = force_c;
                    if (pick_valid_c) begin
                        gnt_nxt       = pick_c;
                        gnt_id_nxt    = onehot_to_idx(pick_c);
                        gnt_valid_nxt = 1'b1;
                    end else begin
                        state_nxt     = ARB_IDLE;
                        gnt_nxt       = '0;
                        gnt_id_nxt    = '0;
                        gnt_valid_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ARB_IDLE;
            ptr       <= ARB_IDW'(RESET_PTR);
            GNT       <= '0;
            GNT_ID    <= '0;
            GNT_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            GNT       <= gnt_nxt;
            GNT_ID    <= gnt_id_nxt;
            GNT_VALID <= gnt_valid_nxt;
            TIMEOUT   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_scs8hd_rr_arb4.sv
// Randomized self-checking bench for scs8hd_rr_arb4 against a behavioural round-robin model.
module tb_scs8hd_rr_arb4;

    localparam int MAX_HOLD  = 4;
    localparam int RESET_PTR = 0;
`ifdef SCS8HD_ARB_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       GNT_VALID;
    logic [1:0] GNT_ID;
    logic       TIMEOUT;

    int errs   = 0;
    int checks = 0;

    // Model: owner is the granted client or -1; hold = grant cycles seen so far.
    int       m_owner;
    int       m_ptr;
    int       m_hold;
    bit [3:0] m_mask;
    bit       m_tmo;

    always #5 CLK = ~CLK;

    scs8hd_rr_arb4 #(.MAX_HOLD(MAX_HOLD), .RESET_PTR(RESET_PTR)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .GNT       (GNT),
        .GNT_VALID (GNT_VALID),
        .GNT_ID    (GNT_ID),
        .TIMEOUT   (TIMEOUT)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int find_winner(input int p, input bit [3:0] elig);
        for (int k = 0; k < 4; k++) begin
            if (elig[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit [3:0] req);
        bit [3:0] elig;
        bit       forced;
        if (rst) begin
            m_owner = -1;
            m_ptr   = RESET_PTR;
            m_hold  = 0;
            m_mask  = '0;
            m_tmo   = 1'b0;
            return;
        end
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            m_owner = find_winner(m_ptr, req & ~m_mask);
            m_hold  = (m_owner >= 0) ? 1 : 0;
        end else begin
            forced = TOUT_EN && req[m_owner] && (m_hold >= MAX_HOLD);
            if (!req[m_owner] || forced) begin
                elig = req & ~m_mask;
                if (forced) begin
                    m_mask[m_owner] = 1'b1;
                    elig[m_owner]   = 1'b0;
                end
                m_tmo   = forced;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = find_winner(m_ptr, elig);
                m_hold  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_hold++;
            end
        end
        m_mask = m_mask & req;
    endtask

    // One clock: drive on negedge, step model at posedge, compare just after it.
    task automatic cycle(input bit rst, input bit [3:0] req);
        logic [3:0] exp_gnt;
        @(negedge CLK);
        RESET = rst;
        REQ   = req;
        @(posedge CLK);
        model_step(rst, req);
        #1;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt",       32'(GNT),       32'(exp_gnt));
        chk("gnt_valid", 32'(GNT_VALID), 32'(m_owner >= 0));
        chk("gnt_id",    32'(GNT_ID),    32'((m_owner >= 0) ? m_owner : 0));
        chk("timeout",   32'(TIMEOUT),   32'(m_tmo));
        chk("onehot",    32'($countones(GNT) <= 1), 32'd1);
    endtask

    initial begin
        bit [3:0] r;
        RESET = 1'b1;
        REQ   = 4'b0000;
        m_owner = -1; m_ptr = RESET_PTR; m_hold = 0; m_mask = '0; m_tmo = 1'b0;

        // Reset priority and hold
        cycle(1'b1, 4'b1010);
        cycle(1'b1, 4'b1010);
        chk("reset_gnt", 32'(GNT), 32'd0);
        cycle(1'b0, 4'b1010);
        chk("first_gnt", 32'(GNT), 32'b0010);
        chk("first_id",  32'(GNT_ID), 32'd1);
        repeat (5) cycle(1'b0, 4'b1010);
        chk("held_gnt", 32'(GNT), 32'b0010);

        // Rotation: owner drops for one cycle after 3 grant cycles
        cycle(1'b1, 4'b0000);
        for (int c = 0; c < 24; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 3) r[m_owner] = 1'b0;
            cycle(1'b0, r);
        end

        // Wrap-around
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0100);
        chk("wrap_g2", 32'(GNT), 32'b0100);
        cycle(1'b0, 4'b0001);
        chk("wrap_g0", 32'(GNT), 32'b0001);
        cycle(1'b0, 4'b1000);
        chk("wrap_g3", 32'(GNT), 32'b1000);

        // Release to empty
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0000);
        chk("empty_valid", 32'(GNT_VALID), 32'd0);
        cycle(1'b0, 4'b0100);
        chk("regrant", 32'(GNT), 32'b0100);

        // Reset mid-grant
        cycle(1'b1, 4'b1111);
        chk("midrst_gnt", 32'(GNT), 32'd0);
        cycle(1'b0, 4'b1111);
        chk("postrst_gnt", 32'(GNT), 32'b0001);

        // Long hold with a competitor: timeout or indefinite hold by build
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0010);
        repeat (10) cycle(1'b0, 4'b1010);
        cycle(1'b0, 4'b1000);
        repeat (3) cycle(1'b0, 4'b1010);

        // Random traffic with occasional reset
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            cycle($urandom_range(0, 299) == 0, r);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
